// File: rtl/ps2_pkg.sv
// Shared constants, state encodings and helpers for the PS/2 key serializer.
// Used by ps2_byte_fifo and ps2_key_serializer.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BIT,
    S_GAP
  } ser_state_t;

  typedef enum logic {
    E_IDLE,
    E_PUSH
  } enq_state_t;

  typedef struct packed {
    logic [1:0] n;
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] b2;
  } key_seq_t;

  // Set-2 byte sequence for one key event: [E0] [F0] code
  function automatic key_seq_t expand(input logic [9:0] key);
    key_seq_t s;
    s = '0;
    unique case ({key[8], key[9]})
      2'b11: begin
        s.n  = 2'd2;
        s.b0 = PS2_EXT;
        s.b1 = key[7:0];
      end
      2'b10: begin
        s.n  = 2'd3;
        s.b0 = PS2_EXT;
        s.b1 = PS2_BRK;
        s.b2 = key[7:0];
      end
      2'b01: begin
        s.n  = 2'd1;
        s.b0 = key[7:0];
      end
      2'b00: begin
        s.n  = 2'd2;
        s.b0 = PS2_BRK;
        s.b1 = key[7:0];
      end
    endcase
    return s;
  endfunction

  // 11-bit device frame, bit 0 first: start, data LSB-first, odd parity, stop
  function automatic logic [10:0] ps2_frame(input logic [7:0] b);
    return {1'b1, ~^b, b, 1'b0};
  endfunction

endpackage

// File: rtl/ps2_byte_fifo.sv
// Synchronous byte FIFO with first-word fall-through output.
// Full/empty come from an extra wrap bit on each pointer.
module ps2_byte_fifo import ps2_pkg::*; #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [7:0]               din,
  input  logic                     pop,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   free
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem_q [DEPTH];
  logic [AW:0] wr_q;
  logic [AW:0] rd_q;
  logic        push_d;
  logic        pop_d;

  assign empty  = (wr_q == rd_q);
  assign full   = (wr_q[AW] != rd_q[AW]) &&
                  (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign free   = (AW+1)'(DEPTH) - (wr_q - rd_q);
  assign dout   = mem_q[rd_q[AW-1:0]];
  assign push_d = push && !full;
  assign pop_d  = pop && !empty;

  // Pointer update; simultaneous push and pop keep occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_d) wr_q <= wr_q + (AW+1)'(1);
      if (pop_d)  rd_q <= rd_q + (AW+1)'(1);
    end
  end

  // Storage write, no reset needed on the data array
  always_ff @(posedge clk) begin
    if (push_d) mem_q[wr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/ps2_key_serializer.sv
// Turns hps_io ps2_key toggle events into a PS/2 device-to-host stream.
// Optional host-inhibit handling is enabled by PS2_SER_INHIBIT_EN.
module ps2_key_serializer import ps2_pkg::*; #(
  parameter int CLK_HALF   = 2000,
  parameter int GAP        = 4000,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [10:0] ps2_key,
  input  logic        ps2_clk_in,
  output logic        ps2_clk_out,
  output logic        ps2_data_out,
  output logic        busy,
  output logic        overflow
);

  localparam int CW = $clog2(CLK_HALF);
  localparam int GW = $clog2(GAP + 1);
  localparam int FW = $clog2(FIFO_DEPTH) + 1;

  logic        primed_q;
  logic        prev_q;
  logic        evt_d;
  key_seq_t    seq_d;

  enq_state_t  enq_q;
  logic [15:0] pend_q;
  logic [1:0]  ecnt_q;
  logic        ovf_q;
  logic        enq_busy_d;
  logic        accept_d;
  logic        drop_d;
  logic        push_d;
  logic [7:0]  din_d;

  logic [7:0]  fifo_dout;
  logic        fifo_full;
  logic        fifo_empty;
  logic [FW-1:0] fifo_free;
  logic        pop_d;

  ser_state_t  st_q;
  logic        clk_q;
  logic        data_q;
  logic [CW-1:0] cnt_q;
  logic [GW-1:0] gcnt_q;
  logic [3:0]  bit_q;
  logic [10:0] sh_q;
  logic        retry_q;
  logic        inhib_d;
  logic        abort_d;

`ifdef PS2_SER_INHIBIT_EN
  assign inhib_d = !ps2_clk_in;
`else
  logic unused_clk_in;
  assign unused_clk_in = ps2_clk_in;
  assign inhib_d = 1'b0;
`endif

  assign abort_d = inhib_d && clk_q && (bit_q != 4'd10);

  assign evt_d      = primed_q && (ps2_key[10] != prev_q);
  assign seq_d      = expand(ps2_key[9:0]);
  assign enq_busy_d = (enq_q == E_PUSH);
  assign accept_d   = evt_d && !enq_busy_d &&
                      (fifo_free >= FW'(seq_d.n));
  assign drop_d     = evt_d && !accept_d;
  assign push_d     = (accept_d || enq_busy_d) && !fifo_full;
  assign din_d      = enq_busy_d ? pend_q[7:0] : seq_d.b0;

  assign pop_d = (st_q == S_IDLE) && !inhib_d &&
                 !retry_q && !fifo_empty;

  assign ps2_clk_out  = clk_q;
  assign ps2_data_out = data_q;
  assign overflow     = ovf_q;
  assign busy         = !fifo_empty || (st_q != S_IDLE) || retry_q;

  ps2_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_sys),
    .rst   (reset),
    .push  (push_d),
    .din   (din_d),
    .pop   (pop_d),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .free  (fifo_free)
  );

  // Toggle edge detect; first cycle after reset only primes
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      primed_q <= 1'b0;
      prev_q   <= 1'b0;
    end else if (!primed_q) begin
      primed_q <= 1'b1;
      prev_q   <= ps2_key[10];
    end else if (evt_d) begin
      prev_q   <= ps2_key[10];
    end
  end

  // ENQ sequencer: byte 0 goes in on the event cycle, the rest follow
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      enq_q  <= E_IDLE;
      pend_q <= '0;
      ecnt_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      ovf_q <= drop_d;
      unique case (enq_q)
        E_IDLE: begin
          if (accept_d && seq_d.n != 2'd1) begin
            enq_q  <= E_PUSH;
            pend_q <= {seq_d.b2, seq_d.b1};
            ecnt_q <= seq_d.n - 2'd1;
          end
        end
        E_PUSH: begin
          pend_q <= {8'h00, pend_q[15:8]};
          ecnt_q <= ecnt_q - 2'd1;
          if (ecnt_q == 2'd1) enq_q <= E_IDLE;
        end
      endcase
    end
  end

  // Serializer: frame bits, half-period timing, inter-frame gap
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      st_q    <= S_IDLE;
      clk_q   <= 1'b1;
      data_q  <= 1'b1;
      cnt_q   <= '0;
      gcnt_q  <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      retry_q <= 1'b0;
    end else begin
      unique case (st_q)
        S_IDLE: begin
          clk_q  <= 1'b1;
          data_q <= 1'b1;
          cnt_q  <= '0;
          bit_q  <= '0;
          if (!inhib_d && (retry_q || !fifo_empty)) begin
            if (!retry_q) sh_q <= ps2_frame(fifo_dout);
            data_q  <= 1'b0;
            retry_q <= 1'b0;
            st_q    <= S_BIT;
          end
        end
        S_BIT: begin
          if (abort_d) begin
            clk_q   <= 1'b1;
            data_q  <= 1'b1;
            cnt_q   <= '0;
            gcnt_q  <= '0;
            retry_q <= 1'b1;
            st_q    <= S_GAP;
          end else if (cnt_q == CW'(CLK_HALF - 1)) begin
            cnt_q <= '0;
            if (clk_q) begin
              clk_q <= 1'b0;
            end else if (bit_q == 4'd10) begin
              clk_q  <= 1'b1;
              data_q <= 1'b1;
              gcnt_q <= '0;
              st_q   <= S_GAP;
            end else begin
              clk_q  <= 1'b1;
              bit_q  <= bit_q + 4'd1;
              data_q <= sh_q[bit_q + 4'd1];
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_GAP: begin
          if (inhib_d) begin
            gcnt_q <= '0;
          end else if (gcnt_q == GW'(GAP - 1)) begin
            st_q <= S_IDLE;
          end else begin
            gcnt_q <= gcnt_q + GW'(1);
          end
        end
        default: st_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/ps2_key_serializer.md
# ps2_key_serializer

Converts the 11-bit `ps2_key` event word delivered by `hps_io` back into a PS/2 device-to-host serial stream (clock + data lines), so cores that embed an original PS/2 keyboard receiver can run unmodified. It sits in `emu` between `hps_io` and the core. It expands each toggle event into Set-2 byte sequences, buffers them in a byte FIFO, and shifts them out as 11-bit PS/2 frames at a programmable bit rate.

## Interface
- `CLK_HALF`, 2000: `clk_sys` cycles per PS/2 clock half-period; minimum 2.
- `GAP`, 4000: idle `clk_sys` cycles between consecutive frames; minimum 1.
- `FIFO_DEPTH`, 8: byte FIFO depth; power of two, minimum 4.
- `clk_sys`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `ps2_key`  in  11  [7:0] scancode, [8] extended, [9] pressed, [10] toggle (event strobe by edge).
- `ps2_clk_in`  in  1  sensed PS/2 clock line (host inhibit); used only with `PS2_SER_INHIBIT_EN`.
- `ps2_clk_out`  out  1  PS/2 clock level; idle 1.
- `ps2_data_out`  out  1  PS/2 data level; idle 1.
- `busy`  out  1  FIFO non-empty or frame in progress.
- `overflow`  out  1  one-cycle pulse when an event is dropped.

## Operation
- Reset values: `ps2_clk_out`=1, `ps2_data_out`=1, `busy`=0, `overflow`=0, FIFO empty, `primed`=0.
- Toggle detect: the first cycle after reset loads `prev_tgl` <= `ps2_key[10]` and sets `primed`, generating no event. Afterwards, `ps2_key[10] != prev_tgl` is an event and updates `prev_tgl`.
- Expansion, in order: `E0` if [8]; `F0` if ![9]; then scancode. Count n = 1..3.
- Admission: if FIFO free slots >= n at the event cycle, enqueue all n bytes, one per cycle over n cycles (ENQ sequencer). Otherwise drop the whole event and pulse `overflow`. Partial events are never enqueued.
- An event arriving while ENQ is still pushing is dropped with an `overflow` pulse.
- Serializer FSM:
  - IDLE: data=1, clk=1. If the FIFO is non-empty, pop a byte into the shift register and go to BIT.
  - BIT: bits 0..10 are start 0, data LSB-first, odd parity, stop 1. Each bit is CLK_HALF cycles with clk=1 and data driven, then CLK_HALF cycles with clk=0. After bit 10's low phase, clk returns to 1 and the FSM goes to GAP.
  - GAP: hold idle for GAP cycles, then return to IDLE.
- Parity = ~^byte, so total ones across data+parity is odd.
- Counters: half-period counter of width $clog2(CLK_HALF); bit index 4 bits, 0..10, no wrap beyond 10.
- FIFO full and empty are tracked with an extra pointer bit. Push and pop in the same cycle are allowed and leave occupancy unchanged.

## Timing
- Event to first frame start (data falls to 0) is 2 cycles when the FIFO is empty and the FSM is idle: one cycle enqueue, one cycle pop.
- Frame length = 22·CLK_HALF cycles. Byte-to-byte spacing = 22·CLK_HALF + GAP + 1.
- Data changes only in the first cycle of a high clock phase, never while clk=0.
- Reset mid-frame: outputs go to 1 asynchronously, the FIFO clears, and the partial frame is discarded. The post-reset priming rule applies.
- `overflow` is registered and asserts the cycle after the offending event.

## Configuration
- `PS2_SER_INHIBIT_EN` defined:
  - In IDLE, a frame does not start while `ps2_clk_in`=0.
  - During BIT, `ps2_clk_in`=0 sampled in a phase where `ps2_clk_out`=1, before bit 10, aborts the frame. The FSM drives idle, waits for `ps2_clk_in`=1 plus GAP, then retransmits the same byte, which stays held rather than popped again.
  - Inhibit observed during bit 10 is ignored; the byte counts as sent.
- Not defined: `ps2_clk_in` is unused, and frames are never aborted.

## Structure
- Package `ps2_pkg` holds:
  - the constants `PS2_EXT = 8'hE0` and `PS2_BRK = 8'hF0`;
  - the serializer state enum `{S_IDLE, S_BIT, S_GAP}`;
  - the ENQ state enum.
- Sub-module `ps2_byte_fifo` is a synchronous FIFO: parameter DEPTH; ports push/din/pop/dout/full/empty/free.
- The top module contains the toggle detect, ENQ sequencer and serializer FSM.

## Test plan
- Make 0x1C with CLK_HALF=4, GAP=8: one frame with bits 0,0,0,1,1,1,0,0,0,0,1 (parity 0); frame length 88 cycles.
- Extended release of 0x75 ([8]=1, [9]=0): frames E0, F0, 75 in order; byte starts 97 cycles apart.
- Make 0x00: parity bit = 1. Make 0xFF: parity bit = 1.
- FIFO_DEPTH=4 with 6 events of 3 bytes back-to-back while the serializer is stalled: only complete events are stored; `overflow` pulses exactly once per dropped event.
- Reset asserted at bit 5: outputs are 1 in the same cycle; no further frames are sent. Toggle state at release produces no event.
- With `PS2_SER_INHIBIT_EN`, hold `ps2_clk_in`=0 at bit 3 for 50 cycles: the frame aborts, then the same byte is resent in full GAP cycles after release. Without the macro, the frame completes unaffected.
